// File: rtl/counter_pkg.sv
// Shared widths, types and reset values for the counter engine.
package counter_pkg;

    localparam int unsigned CNT_WIDTH     = 32;
    localparam int unsigned CNT_THRESHOLD = 1000;

    typedef logic [CNT_WIDTH-1:0] counter_t;

    // Config register payload as written through the config strobe.
    typedef struct packed {
        logic en;
        logic dir;
    } cfg_t;

    localparam counter_t COUNTER_RST = '0;
    localparam logic     EN_RST      = 1'b0;
    localparam logic     DIR_RST     = 1'b1;
    localparam logic     LT_RST      = 1'b1;
    localparam cfg_t     CFG_RST     = '{en: EN_RST, dir: DIR_RST};

endpackage

// File: rtl/counter_prescaler.sv
// Prescaler: divides clk into count ticks while enabled; held at zero while disabled.
module counter_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clear_i,
    output logic tick_c_o
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;

    assign tick_c_o = en_i && (presc_q == LAST);

    always_comb begin
        presc_d = presc_q + PW'(1);
        if (!en_i || clear_i || tick_c_o) begin
            presc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/counter_core.sv
// Counter engine behind the Avalon-MM front-end: counter, config, threshold status and sticky irq.
module counter_core
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH     = CNT_WIDTH,
    parameter int unsigned THRESHOLD = CNT_THRESHOLD,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             counterRe,
    input  logic             counterWe,
    input  logic [WIDTH-1:0] counterIn,
    output logic [WIDTH-1:0] counterOut,
    input  logic             counterConfigRe,
    input  logic             counterConfigWe,
    input  logic             counterEnIn,
    input  logic             counterDirIn,
    output logic             counterEnOut,
    output logic             counterDirOut,
    input  logic             counterStatusRe,
    output logic             counterLT1000Out,
    output logic             counterIrq
);

    logic [WIDTH-1:0] counter_q;
    logic [WIDTH-1:0] counter_d;
    cfg_t             cfg_q;
    cfg_t             cfg_d;
    logic             lt_prev_q;
    logic             irq_q;
    logic             irq_d;
    logic             lt_c;
    logic             cross_c;
    logic             tick_c;
    logic             unused_re;

    // Read strobes have no side effect on this block.
    assign unused_re = counterRe ^ counterConfigRe;

    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (reset),
        .en_i     (cfg_q.en),
        .clear_i  (counterWe),
        .tick_c_o (tick_c)
    );

    assign lt_c    = counter_q < WIDTH'(THRESHOLD);
    assign cross_c = lt_prev_q ^ lt_c;

    // Write data overrides a tick; ticks use the direction in force this cycle.
    always_comb begin
        counter_d = counter_q;
        if (counterWe) begin
            counter_d = counterIn;
        end else if (tick_c) begin
            counter_d = cfg_q.dir ? counter_q + WIDTH'(1) : counter_q - WIDTH'(1);
        end
    end

    always_comb begin
        cfg_d = cfg_q;
        if (counterConfigWe) begin
            cfg_d = '{en: counterEnIn, dir: counterDirIn};
        end
    end

    // A new crossing wins over a status read in the same cycle.
    always_comb begin
        irq_d = irq_q;
        if (counterStatusRe) begin
            irq_d = 1'b0;
        end
        if (cross_c) begin
            irq_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter_q <= WIDTH'(COUNTER_RST);
            cfg_q     <= CFG_RST;
            lt_prev_q <= LT_RST;
            irq_q     <= 1'b0;
        end else begin
            counter_q <= counter_d;
            cfg_q     <= cfg_d;
            lt_prev_q <= lt_c;
            irq_q     <= irq_d;
        end
    end

    assign counterOut       = counter_q;
    assign counterEnOut     = cfg_q.en;
    assign counterDirOut    = cfg_q.dir;
    assign counterLT1000Out = lt_c;
    assign counterIrq       = irq_q;

endmodule

// File: tb/tb_counter_core.sv
// Bench for counter_core: PRESCALE=1 and PRESCALE=4 instances against a behavioural model.
module tb_counter_core;

    localparam logic [31:0] THR = 32'd1000;

    logic        clk;
    logic        reset;
    logic        counterRe;
    logic        counterWe;
    logic [31:0] counterIn;
    logic        counterConfigRe;
    logic        counterConfigWe;
    logic        counterEnIn;
    logic        counterDirIn;
    logic        counterStatusRe;

    logic [31:0] cnt_o [2];
    logic        en_o  [2];
    logic        dir_o [2];
    logic        lt_o  [2];
    logic        irq_o [2];

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    counter_core #(.WIDTH(32), .THRESHOLD(1000), .PRESCALE(1)) u_p1 (
        .clk(clk), .reset(reset),
        .counterRe(counterRe), .counterWe(counterWe), .counterIn(counterIn),
        .counterOut(cnt_o[0]),
        .counterConfigRe(counterConfigRe), .counterConfigWe(counterConfigWe),
        .counterEnIn(counterEnIn), .counterDirIn(counterDirIn),
        .counterEnOut(en_o[0]), .counterDirOut(dir_o[0]),
        .counterStatusRe(counterStatusRe),
        .counterLT1000Out(lt_o[0]), .counterIrq(irq_o[0])
    );

    counter_core #(.WIDTH(32), .THRESHOLD(1000), .PRESCALE(4)) u_p4 (
        .clk(clk), .reset(reset),
        .counterRe(counterRe), .counterWe(counterWe), .counterIn(counterIn),
        .counterOut(cnt_o[1]),
        .counterConfigRe(counterConfigRe), .counterConfigWe(counterConfigWe),
        .counterEnIn(counterEnIn), .counterDirIn(counterDirIn),
        .counterEnOut(en_o[1]), .counterDirOut(dir_o[1]),
        .counterStatusRe(counterStatusRe),
        .counterLT1000Out(lt_o[1]), .counterIrq(irq_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: counting phase = enabled cycles since enable/write,
    // irq event = threshold side of the value now differs from the value one cycle ago.
    logic [31:0] m_cnt   [2];
    logic [31:0] m_prev  [2];
    bit          m_en    [2];
    bit          m_dir   [2];
    bit          m_irq   [2];
    int          m_phase [2];

    function automatic int ps(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    function automatic bit f_tick(input bit en, input int phase, input int p);
        return en && (((phase + 1) % p) == 0);
    endfunction

    always @(posedge clk or negedge reset) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                m_cnt[k]   <= 32'd0;
                m_prev[k]  <= 32'd0;
                m_en[k]    <= 1'b0;
                m_dir[k]   <= 1'b1;
                m_irq[k]   <= 1'b0;
                m_phase[k] <= 0;
            end else begin
                m_cnt[k] <= counterWe ? counterIn :
                            f_tick(m_en[k], m_phase[k], ps(k)) ?
                                (m_dir[k] ? m_cnt[k] + 32'd1 : m_cnt[k] - 32'd1) :
                            m_cnt[k];
                m_phase[k] <= (counterWe || !m_en[k]) ? 0 : m_phase[k] + 1;
                m_en[k]    <= counterConfigWe ? counterEnIn  : m_en[k];
                m_dir[k]   <= counterConfigWe ? counterDirIn : m_dir[k];
                m_irq[k]   <= ((m_cnt[k] < THR) != (m_prev[k] < THR)) ? 1'b1 :
                              counterStatusRe ? 1'b0 : m_irq[k];
                m_prev[k]  <= m_cnt[k];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("p%0d cnt", ps(k)), cnt_o[k], m_cnt[k]);
                chk($sformatf("p%0d en", ps(k)),  32'(en_o[k]),  32'(m_en[k]));
                chk($sformatf("p%0d dir", ps(k)), 32'(dir_o[k]), 32'(m_dir[k]));
                chk($sformatf("p%0d lt", ps(k)),  32'(lt_o[k]),  32'(m_cnt[k] < THR));
                chk($sformatf("p%0d irq", ps(k)), 32'(irq_o[k]), 32'(m_irq[k]));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_cnt(input logic [31:0] v);
        counterWe = 1'b1;
        counterIn = v;
        cyc(1);
        counterWe = 1'b0;
    endtask

    task automatic write_cfg(input bit en, input bit dir);
        counterConfigWe = 1'b1;
        counterEnIn     = en;
        counterDirIn    = dir;
        cyc(1);
        counterConfigWe = 1'b0;
    endtask

    task automatic status_pulse();
        counterStatusRe = 1'b1;
        cyc(1);
        counterStatusRe = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk({tag, " cnt"}, cnt_o[k], 32'd0);
            chk({tag, " en"},  32'(en_o[k]),  32'd0);
            chk({tag, " dir"}, 32'(dir_o[k]), 32'd1);
            chk({tag, " lt"},  32'(lt_o[k]),  32'd1);
            chk({tag, " irq"}, 32'(irq_o[k]), 32'd0);
        end
    endtask

    initial begin
        reset           = 1'b0;
        counterRe       = 1'b0;
        counterWe       = 1'b0;
        counterIn       = '0;
        counterConfigRe = 1'b0;
        counterConfigWe = 1'b0;
        counterEnIn     = 1'b0;
        counterDirIn    = 1'b0;
        counterStatusRe = 1'b0;

        // Reset, release, idle
        cyc(3);
        chk_reset_vals("rst held");
        reset = 1'b1;
        cmp_en = 1'b1;
        cyc(1);
        chk_reset_vals("rst released");
        cyc(20);
        chk("idle cnt p1", cnt_o[0], 32'd0);
        chk("idle cnt p4", cnt_o[1], 32'd0);

        // Prescaled counting
        write_cfg(1'b1, 1'b1);
        cyc(40);
        chk("presc p4 40clk", cnt_o[1], 32'd10);
        chk("presc p1 40clk", cnt_o[0], 32'd40);

        // Upward threshold crossing and status clear
        write_cfg(1'b0, 1'b1);
        write_cnt(32'd998);
        chk("load 998", cnt_o[0], 32'd998);
        write_cfg(1'b1, 1'b1);
        cyc(1);
        chk("up 999", cnt_o[0], 32'd999);
        chk("lt at 999", 32'(lt_o[0]), 32'd1);
        cyc(1);
        chk("up 1000", cnt_o[0], 32'd1000);
        chk("lt at 1000", 32'(lt_o[0]), 32'd0);
        chk("irq same clk", 32'(irq_o[0]), 32'd0);
        cyc(1);
        chk("irq after cross", 32'(irq_o[0]), 32'd1);
        status_pulse();
        chk("irq cleared", 32'(irq_o[0]), 32'd0);

        // Wrap down and up
        write_cfg(1'b0, 1'b1);
        write_cnt(32'd0);
        cyc(2);
        status_pulse();
        chk("pre-wrap irq", 32'(irq_o[0]), 32'd0);
        chk("pre-wrap cnt", cnt_o[0], 32'd0);
        write_cfg(1'b1, 1'b0);
        cyc(1);
        chk("wrap down cnt", cnt_o[0], 32'hFFFF_FFFF);
        chk("wrap down lt", 32'(lt_o[0]), 32'd0);
        chk("wrap down irq early", 32'(irq_o[0]), 32'd0);
        cyc(1);
        chk("wrap down irq", 32'(irq_o[0]), 32'd1);
        write_cfg(1'b0, 1'b1);
        write_cnt(32'hFFFF_FFFF);
        status_pulse();
        chk("pre-wrap-up irq", 32'(irq_o[0]), 32'd0);
        write_cfg(1'b1, 1'b1);
        chk("pre-wrap-up cnt", cnt_o[0], 32'hFFFF_FFFF);
        cyc(1);
        chk("wrap up cnt", cnt_o[0], 32'd0);
        chk("wrap up lt", 32'(lt_o[0]), 32'd1);
        cyc(1);
        chk("wrap up irq", 32'(irq_o[0]), 32'd1);

        // Write beats tick; set beats status clear
        status_pulse();
        chk("irq clr2", 32'(irq_o[0]), 32'd0);
        write_cnt(32'd500);
        chk("write over tick", cnt_o[0], 32'd500);
        write_cnt(32'd1000);
        counterStatusRe = 1'b1;
        cyc(1);
        counterStatusRe = 1'b0;
        chk("set wins clear", 32'(irq_o[0]), 32'd1);

        // Asynchronous reset mid-cycle while counting with irq pending
        cyc(3);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_vals("async rst");
        cyc(2);
        reset = 1'b1;
        chk("after release cnt", cnt_o[0], 32'd0);
        write_cfg(1'b1, 1'b1);
        cyc(5);
        chk("resume p1", cnt_o[0], 32'd5);
        chk("resume p4", cnt_o[1], 32'd1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            int sel;
            counterRe       = 1'($urandom_range(0, 1));
            counterConfigRe = 1'($urandom_range(0, 1));
            counterWe       = ($urandom_range(0, 7) == 0);
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       counterIn = 32'($urandom_range(990, 1010));
                1:       counterIn = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                2:       counterIn = 32'($urandom_range(0, 3));
                default: counterIn = 32'($urandom);
            endcase
            counterConfigWe = ($urandom_range(0, 9) == 0);
            counterEnIn     = ($urandom_range(0, 3) != 0);
            counterDirIn    = 1'($urandom_range(0, 1));
            counterStatusRe = ($urandom_range(0, 5) == 0);
            cyc(1);
        end
        counterWe       = 1'b0;
        counterConfigWe = 1'b0;
        counterStatusRe = 1'b0;
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
